// File: rtl/if_prefetch_buf.sv
`default_nettype none
// ============================================================================
// if_prefetch_buf : fetch PC + DEPTH-entry {pc, instr} prefetch FIFO to decode
// Option macro: IFB_MISALIGN_CHK_EN (adds misalign_err).   Rev 1.0
// ============================================================================
module if_prefetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_en,
    output logic [31:0]             im_addr,
    input  logic [31:0]             im_dout,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_instr,
`ifdef IFB_MISALIGN_CHK_EN
    output logic                    misalign_err,
`endif
    output logic [$clog2(DEPTH):0]  level
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [31:0]        r_fetch_pc;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_level;
    logic [31:0]        r_pc_mem    [DEPTH];
    logic [31:0]        r_instr_mem [DEPTH];

    logic w_deq;
    logic w_enq;

    assign w_deq = out_valid & out_ready;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign w_enq = fetch_en & ~redirect_valid & ((r_level != c_FULL) | w_deq);

    assign im_addr   = r_fetch_pc;
    assign out_valid = (r_level != '0);
    assign out_pc    = r_pc_mem[r_rd_ptr];
    assign out_instr = r_instr_mem[r_rd_ptr];
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_enq) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= im_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
        end else if (redirect_valid) begin
            // Flush wins over any handshake in this cycle.
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr   <= r_wr_ptr + c_PTR_W'(1);
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_level <= r_level + (c_PTR_W + 1)'(1);
                2'b01:   r_level <= r_level - (c_PTR_W + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef IFB_MISALIGN_CHK_EN
    logic r_misalign_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= redirect_valid & (|redirect_pc[1:0]);
        end
    end

    assign misalign_err = r_misalign_err;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = |redirect_pc[1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_buf.sv
`default_nettype none
// Randomised and directed bench for if_prefetch_buf against a queue-based model.
module tb_if_prefetch_buf;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] im_addr;
    logic [31:0] im_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  level;
`ifdef IFB_MISALIGN_CHK_EN
    logic        misalign_err;
    bit          m_mis;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] q[$];
    logic [31:0] m_pc;
    bit          m_fresh;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    assign im_dout = mem_word(im_addr);

    always #5 clk = ~clk;

    if_prefetch_buf #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .im_addr        (im_addr),
        .im_dout        (im_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
`ifdef IFB_MISALIGN_CHK_EN
        .misalign_err   (misalign_err),
`endif
        .level          (level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare DUT against model, then advance the model.
    task automatic step(input logic en, input logic rdy, input logic rv,
                        input logic [31:0] rpc, input logic rn);
        bit deq;
        bit enq;
        @(negedge clk);
        fetch_en       = en;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        rst_n          = rn;
        #1;
        check("im_addr", im_addr, m_pc);
        check("level", 32'(level), 32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_pc", out_pc, q[0][63:32]);
            check("out_instr", out_instr, q[0][31:0]);
        end else if (m_fresh) begin
            check("out_pc_clr", out_pc, 32'h0);
            check("out_instr_clr", out_instr, 32'h0);
        end
`ifdef IFB_MISALIGN_CHK_EN
        check("misalign_err", 32'(misalign_err), 32'(m_mis));
`endif
        @(posedge clk);
`ifdef IFB_MISALIGN_CHK_EN
        m_mis = rn && rv && (rpc[1:0] != 2'b00);
`endif
        if (!rn) begin
            q.delete();
            m_pc    = RESET_PC;
            m_fresh = 1'b1;
        end else if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            deq = (q.size() != 0) && rdy;
            enq = en && ((q.size() < DEPTH) || deq);
            if (deq) void'(q.pop_front());
            if (enq) begin
                q.push_back({m_pc, mem_word(m_pc)});
                m_pc    = m_pc + 32'd4;
                m_fresh = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        q.delete();
        m_pc    = RESET_PC;
        m_fresh = 1'b1;
`ifdef IFB_MISALIGN_CHK_EN
        m_mis   = 1'b0;
`endif

        // Saturate with decode stalled.
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        check("sat_addr", im_addr, 32'h10);
        check("sat_level", 32'(level), 32'd4);

        // Drain and stream.
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect while full, then misaligned and aligned redirects.
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h102, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h104, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Back-to-back redirects, PC wrap at the top of memory.
        step(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF7, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Reset mid-stream with three entries queued.
        step(1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h500, 1'b0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // fetch_en low with two entries queued, then resume.
        step(1'b1, 1'b1, 1'b1, 32'h400, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        repeat (3000) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0,
                 $urandom,
                 $urandom_range(0, 99) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
